// File: rtl/frac_lerp.sv
// frac_lerp: sample-pair FIFO feeding a three-stage linear interpolator.
// Each weight pulse pops the oldest (s0, s1) pair and yields s0 + w*(s1 - s0).
// Optional feature: define LERP_ROUND_EN to round half toward +inf instead of
// flooring the scaled difference.
module frac_lerp #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned FRAC_W = 16,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [DATA_W-1:0]            s_data0,
    input  logic [DATA_W-1:0]            s_data1,
    input  logic                         f_valid,
    input  logic [FRAC_W:0]              f_frac,
    output logic                         o_valid,
    output logic [DATA_W-1:0]            o_data,
    output logic                         o_sat,
    output logic [$clog2(DEPTH):0]       o_level,
    input  logic                         clr_err,
    output logic                         o_err_orphan
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned PW = DATA_W + FRAC_W + 2;

    localparam logic [LW-1:0]         LEVEL_FULL = LW'(DEPTH);
    localparam logic [FRAC_W:0]       W_ONE      = {1'b1, {FRAC_W{1'b0}}};
`ifdef LERP_ROUND_EN
    localparam logic signed [PW-1:0]  ROUND_BIAS = {{(PW - FRAC_W){1'b0}}, 1'b1,
                                                    {(FRAC_W - 1){1'b0}}};
`endif

    // ---------------------------------------------------------------- FIFO
    logic [DATA_W-1:0] mem0 [DEPTH];
    logic [DATA_W-1:0] mem1 [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [LW-1:0]     level;
    logic              push;
    logic              pop;
    logic              orphan;

    // Handshake decode works off registered level only, so a same-cycle push
    // is never visible to a weight (no bypass).
    always_comb begin
        s_ready = (level != LEVEL_FULL);
        push    = s_valid && s_ready;
        pop     = f_valid && (level != '0);
        orphan  = f_valid && (level == '0);
    end

    assign o_level = level;

    // Sample storage; no reset needed since level gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem0[wr_ptr] <= s_data0;
            mem1[wr_ptr] <= s_data1;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Sticky orphan flag; a new orphan beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_err_orphan <= 1'b0;
        end else if (orphan) begin
            o_err_orphan <= 1'b1;
        end else if (clr_err) begin
            o_err_orphan <= 1'b0;
        end
    end

    // ------------------------------------------------- S1: clamp and diff
    logic                     sat_in;
    logic [FRAC_W:0]          w_in;
    logic signed [DATA_W:0]   diff_in;

    // Weight clamp to 1.0 and signed endpoint difference of the head pair.
    always_comb begin
        sat_in  = (f_frac > W_ONE);
        w_in    = sat_in ? W_ONE : f_frac;
        diff_in = $signed({1'b0, mem1[rd_ptr]}) - $signed({1'b0, mem0[rd_ptr]});
    end

    logic                     v1;
    logic                     sat1;
    logic [DATA_W-1:0]        s0_1;
    logic signed [DATA_W:0]   diff1;
    logic [FRAC_W:0]          w1;

    // Stage 1 register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1    <= 1'b0;
            sat1  <= 1'b0;
            s0_1  <= '0;
            diff1 <= '0;
            w1    <= '0;
        end else begin
            v1 <= pop;
            if (pop) begin
                sat1  <= sat_in;
                s0_1  <= mem0[rd_ptr];
                diff1 <= diff_in;
                w1    <= w_in;
            end
        end
    end

    // --------------------------------------------------------- S2: multiply
    logic signed [PW-1:0] diff_ext;
    logic signed [PW-1:0] w_ext;
    logic signed [PW-1:0] prod_in;

    // Full-width signed product; |diff*w| < 2^(DATA_W+FRAC_W+1) so it fits.
    always_comb begin
        diff_ext = {{(PW - DATA_W - 1){diff1[DATA_W]}}, diff1};
        w_ext    = {{(PW - FRAC_W - 1){1'b0}}, w1};
        prod_in  = diff_ext * w_ext;
    end

    logic                  v2;
    logic                  sat2;
    logic [DATA_W-1:0]     s0_2;
    logic signed [PW-1:0]  prod2;

    // Stage 2 register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2    <= 1'b0;
            sat2  <= 1'b0;
            s0_2  <= '0;
            prod2 <= '0;
        end else begin
            v2 <= v1;
            if (v1) begin
                sat2  <= sat1;
                s0_2  <= s0_1;
                prod2 <= prod_in;
            end
        end
    end

    // ----------------------------------------------------- S3: scale and add
    logic signed [PW-1:0]  rnd;
    logic signed [PW-1:0]  shifted;
    logic [DATA_W+1:0]     sum;
    logic                  unused_bits;

    // Scale back to sample units and add the base; result lies in [s0, s1].
    always_comb begin
`ifdef LERP_ROUND_EN
        rnd = prod2 + ROUND_BIAS;
`else
        rnd = prod2;
`endif
        shifted     = rnd >>> FRAC_W;
        sum         = {2'b00, s0_2} + shifted[DATA_W+1:0];
        unused_bits = ^{shifted[PW-1:DATA_W+2], sum[DATA_W+1:DATA_W]};
    end

    // Stage 3 / output register; data and sat hold between result pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_valid <= 1'b0;
            o_data  <= '0;
            o_sat   <= 1'b0;
        end else begin
            o_valid <= v2;
            if (v2) begin
                o_data <= sum[DATA_W-1:0];
                o_sat  <= sat2;
            end
        end
    end

endmodule

// File: tb/tb_frac_lerp.sv
// Self-checking bench for frac_lerp: directed scenarios plus a randomized run
// against a queue-based arithmetic reference model.
module tb_frac_lerp;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned FRAC_W = 16;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned LW     = $clog2(DEPTH) + 1;
    localparam longint      ONE    = longint'(1) << FRAC_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data0;
    logic [DATA_W-1:0] s_data1;
    logic              f_valid;
    logic [FRAC_W:0]   f_frac;
    logic              o_valid;
    logic [DATA_W-1:0] o_data;
    logic              o_sat;
    logic [LW-1:0]     o_level;
    logic              clr_err;
    logic              o_err_orphan;

    int checks = 0;
    int errors = 0;

    frac_lerp #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data0      (s_data0),
        .s_data1      (s_data1),
        .f_valid      (f_valid),
        .f_frac       (f_frac),
        .o_valid      (o_valid),
        .o_data       (o_data),
        .o_sat        (o_sat),
        .o_level      (o_level),
        .clr_err      (clr_err),
        .o_err_orphan (o_err_orphan)
    );

    always #5 clk = ~clk;

    // Reference: s0 + floor((s1 - s0) * w / 2^F) (optionally +0.5 before floor).
    function automatic logic [DATA_W:0] ref_lerp(input longint s0, input longint s1,
                                                 input longint fr);
        longint w;
        longint p;
        longint r;
        logic   sat;
        sat = (fr > ONE);
        w   = sat ? ONE : fr;
        p   = (s1 - s0) * w;
`ifdef LERP_ROUND_EN
        p   = p + (ONE / 2);
`endif
        r   = s0 + (p >>> FRAC_W);
        return {sat, r[DATA_W-1:0]};
    endfunction

    // Drive one cycle of inputs from a negedge, return at the next negedge.
    task automatic tick(input logic sv, input logic [DATA_W-1:0] d0,
                        input logic [DATA_W-1:0] d1, input logic fv,
                        input logic [FRAC_W:0] fr, input logic clr);
        s_valid = sv; s_data0 = d0; s_data1 = d1;
        f_valid = fv; f_frac = fr; clr_err = clr;
        @(posedge clk);
        @(negedge clk);
        s_valid = 1'b0; f_valid = 1'b0; clr_err = 1'b0;
    endtask

    task automatic idle();
        tick(1'b0, '0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic push(input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1);
        tick(1'b1, d0, d1, 1'b0, '0, 1'b0);
    endtask

    task automatic weight(input logic [FRAC_W:0] fr);
        tick(1'b0, '0, '0, 1'b1, fr, 1'b0);
    endtask

    // Called right after a weight tick; lat = cycles from weight to o_valid.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (o_valid !== 1'b1 && lat < 8) begin
            idle();
            lat++;
        end
    endtask

    task automatic test_reset();
        checks++;
        if (s_ready !== 1'b1 || o_valid !== 1'b0 || o_sat !== 1'b0 ||
            o_err_orphan !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got rdy=%b v=%b sat=%b err=%b want 1 0 0 0",
                     s_ready, o_valid, o_sat, o_err_orphan);
        end
        checks++;
        if (o_data !== '0 || o_level !== '0) begin
            errors++;
            $display("FAIL reset_data: got data=%0d level=%0d want 0 0", o_data, o_level);
        end
        rst_n = 1'b1;
        idle();
    endtask

    task automatic test_basic();
        int lat;
        push(16'd100, 16'd200);
        weight(17'h08000);
        wait_valid(lat);
        checks++;
        if (lat !== 3 || o_data !== 16'd150 || o_sat !== 1'b0) begin
            errors++;
            $display("FAIL basic_mid: got lat=%0d data=%0d sat=%b want 3 150 0",
                     lat, o_data, o_sat);
        end
        idle();
        checks++;
        if (o_valid !== 1'b0 || o_data !== 16'd150) begin
            errors++;
            $display("FAIL basic_hold: got v=%b data=%0d want 0 150", o_valid, o_data);
        end
    endtask

    task automatic test_rounding();
        int lat;
`ifdef LERP_ROUND_EN
        logic [DATA_W-1:0] exp_v = 16'd2;
`else
        logic [DATA_W-1:0] exp_v = 16'd1;
`endif
        push(16'd3, 16'd0);
        weight(17'h08000);
        wait_valid(lat);
        checks++;
        if (lat !== 3 || o_data !== exp_v) begin
            errors++;
            $display("FAIL round_down: got lat=%0d data=%0d want 3 %0d", lat, o_data, exp_v);
        end
        push(16'd0, 16'd3);
        weight(17'h08000);
        wait_valid(lat);
        checks++;
        if (lat !== 3 || o_data !== exp_v) begin
            errors++;
            $display("FAIL round_up: got lat=%0d data=%0d want 3 %0d", lat, o_data, exp_v);
        end
    endtask

    task automatic test_clamp();
        logic [FRAC_W:0]   frs  [3] = '{17'h04000, 17'h18000, 17'h10000};
        logic [DATA_W-1:0] exps [3] = '{16'd175, 16'd100, 16'd100};
        logic              sats [3] = '{1'b0, 1'b1, 1'b0};
        int lat;
        for (int i = 0; i < 3; i++) push(16'd200, 16'd100);
        for (int i = 0; i < 3; i++) begin
            weight(frs[i]);
            wait_valid(lat);
            checks++;
            if (lat !== 3 || o_data !== exps[i] || o_sat !== sats[i]) begin
                errors++;
                $display("FAIL clamp_%0d: got lat=%0d data=%0d sat=%b want 3 %0d %b",
                         i, lat, o_data, o_sat, exps[i], sats[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [DATA_W-1:0] got [$];
        for (int i = 0; i < 4; i++) push(DATA_W'(7 * i), DATA_W'(11 * (i + 1)));
        checks++;
        if (o_level !== LW'(4) || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL full: got level=%0d rdy=%b want 4 0", o_level, s_ready);
        end
        push(16'd99, 16'd99);
        checks++;
        if (o_level !== LW'(4)) begin
            errors++;
            $display("FAIL full_hold: got level=%0d want 4", o_level);
        end
        for (int i = 0; i < 4; i++) begin
            weight(17'h10000);
            if (o_valid) got.push_back(o_data);
            if (i == 0) begin
                checks++;
                if (o_level !== LW'(3) || s_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL after_pop: got level=%0d rdy=%b want 3 1", o_level, s_ready);
                end
            end
        end
        for (int i = 0; i < 5; i++) begin
            idle();
            if (o_valid) got.push_back(o_data);
        end
        checks++;
        if (got.size() !== 4) begin
            errors++;
            $display("FAIL b2b_count: got %0d results want 4", got.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got[i] !== DATA_W'(11 * (i + 1))) begin
                    errors++;
                    $display("FAIL b2b_order_%0d: got %0d want %0d", i, got[i], 11 * (i + 1));
                end
            end
        end
    endtask

    task automatic test_orphan();
        int pulses = 0;
        int lat;
        tick(1'b1, 16'd5, 16'd6, 1'b1, 17'h10000, 1'b0);
        for (int i = 0; i < 4; i++) begin
            if (o_valid) pulses++;
            idle();
        end
        checks++;
        if (pulses !== 0 || o_err_orphan !== 1'b1 || o_level !== LW'(1)) begin
            errors++;
            $display("FAIL orphan: got pulses=%0d err=%b level=%0d want 0 1 1",
                     pulses, o_err_orphan, o_level);
        end
        weight(17'h10000);
        wait_valid(lat);
        checks++;
        if (lat !== 3 || o_data !== 16'd6) begin
            errors++;
            $display("FAIL orphan_next: got lat=%0d data=%0d want 3 6", lat, o_data);
        end
        tick(1'b0, '0, '0, 1'b0, '0, 1'b1);
        checks++;
        if (o_err_orphan !== 1'b0) begin
            errors++;
            $display("FAIL orphan_clr: got err=%b want 0", o_err_orphan);
        end
        tick(1'b0, '0, '0, 1'b1, 17'h10000, 1'b1);
        checks++;
        if (o_err_orphan !== 1'b1) begin
            errors++;
            $display("FAIL orphan_set_wins: got err=%b want 1", o_err_orphan);
        end
        tick(1'b0, '0, '0, 1'b0, '0, 1'b1);
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        push(16'd1, 16'd2);
        push(16'd3, 16'd4);
        weight(17'h10000);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        if (o_valid) pulses++;
        rst_n = 1'b1;
        checks++;
        if (o_level !== '0 || s_ready !== 1'b1 || o_data !== '0) begin
            errors++;
            $display("FAIL reset_mid: got level=%0d rdy=%b data=%0d want 0 1 0",
                     o_level, s_ready, o_data);
        end
        for (int i = 0; i < 6; i++) begin
            idle();
            if (o_valid) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL reset_mid_pulse: got %0d pulses want 0", pulses);
        end
    endtask

    typedef struct {
        longint s0;
        longint s1;
    } pair_t;

    typedef struct {
        logic [DATA_W:0] res;
        int              due;
    } res_t;

    task automatic test_random();
        pair_t mq [$];
        res_t  rq [$];
        logic  err = 1'b0;
        for (int k = 0; k < 600 + 6; k++) begin
            logic              sv  = 1'b0;
            logic              fv  = 1'b0;
            logic              clr = 1'b0;
            logic [DATA_W-1:0] d0  = DATA_W'($urandom);
            logic [DATA_W-1:0] d1  = DATA_W'($urandom);
            logic [FRAC_W:0]   fr;
            int                pre = mq.size();
            pair_t             hd;
            res_t              r;
            if ($urandom_range(0, 3) == 0) fr = ($urandom_range(0, 1) == 0) ? 17'h10000 : '0;
            else                           fr = (FRAC_W + 1)'($urandom_range(0, 'h1FFFF));
            if (k < 600) begin
                sv  = ($urandom_range(0, 2) != 0);
                fv  = ($urandom_range(0, 2) == 0);
                clr = ($urandom_range(0, 15) == 0);
            end
            if (fv && pre > 0) begin
                hd    = mq.pop_front();
                r.res = ref_lerp(hd.s0, hd.s1, longint'(fr));
                r.due = k + 2;
                rq.push_back(r);
            end
            if (sv && pre < DEPTH) mq.push_back('{longint'(d0), longint'(d1)});
            if (fv && pre == 0) err = 1'b1;
            else if (clr)       err = 1'b0;
            tick(sv, d0, d1, fv, fr, clr);
            checks++;
            if (rq.size() > 0 && rq[0].due == k) begin
                r = rq.pop_front();
                if (o_valid !== 1'b1 || {o_sat, o_data} !== r.res) begin
                    errors++;
                    $display("FAIL rand_res k=%0d: got v=%b sat=%b data=%0d want 1 %b %0d",
                             k, o_valid, o_sat, o_data, r.res[DATA_W], r.res[DATA_W-1:0]);
                end
            end else if (o_valid !== 1'b0) begin
                errors++;
                $display("FAIL rand_spurious k=%0d: got o_valid=1 want 0", k);
            end
            checks++;
            if (o_level !== LW'(mq.size()) || s_ready !== (mq.size() != DEPTH) ||
                o_err_orphan !== err) begin
                errors++;
                $display("FAIL rand_state k=%0d: got level=%0d rdy=%b err=%b want %0d %b %b",
                         k, o_level, s_ready, o_err_orphan, mq.size(),
                         mq.size() != DEPTH, err);
            end
        end
        checks++;
        if (rq.size() !== 0) begin
            errors++;
            $display("FAIL rand_drain: got %0d outstanding want 0", rq.size());
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data0 = '0;
        s_data1 = '0;
        f_valid = 1'b0;
        f_frac  = '0;
        clr_err = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_basic();
        test_rounding();
        test_clamp();
        test_back_to_back();
        test_orphan();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
